// File: rtl/axis_sum_responder.sv
// axis_sum_responder: NoC endpoint answering each request packet with {tag,count} and payload-sum beats.
// Define AXIS_SUM_RESPONDER_DEST_CHECK_EN to flag request beats whose TDEST differs from MY_ADDR.
module axis_sum_responder #(
    parameter int TDATAW = 32,
    parameter int TDESTW = 4,
    parameter int NUM_PACKETS = 16,
    parameter int MAX_BEATS = 255,
    parameter logic [TDESTW-1:0] MY_ADDR = TDESTW'(4'h3)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              AXIS_S_TVALID,
    output logic              AXIS_S_TREADY,
    input  logic [TDATAW-1:0] AXIS_S_TDATA,
    input  logic              AXIS_S_TLAST,
    input  logic [TDESTW-1:0] AXIS_S_TDEST,
    output logic              AXIS_M_TVALID,
    input  logic              AXIS_M_TREADY,
    output logic [TDATAW-1:0] AXIS_M_TDATA,
    output logic              AXIS_M_TLAST,
    output logic [TDESTW-1:0] AXIS_M_TDEST,
    output logic              DONE,
    output logic              ERR
);
    typedef enum logic [1:0] {IDLE, PAYLOAD, RSP_HDR, RSP_SUM} state_t;
    state_t state, state_nxt;
    logic [TDESTW-1:0] ret_addr;
    logic [15:0] tag, count;
    logic [TDATAW-1:0] sum;
    logic [31:0] rsp_cnt;
    logic err, s_acc, m_acc, dest_err, beat_err;
    assign s_acc = AXIS_S_TVALID && AXIS_S_TREADY;
    assign m_acc = AXIS_M_TVALID && AXIS_M_TREADY;
`ifdef AXIS_SUM_RESPONDER_DEST_CHECK_EN
    assign dest_err = AXIS_S_TDEST != MY_ADDR;
`else
    logic unused_dest;
    assign unused_dest = ^{AXIS_S_TDEST, MY_ADDR};
    assign dest_err = 1'b0;
`endif
    // an overflowing beat is still summed; only the count saturates
    assign beat_err = dest_err || (state == PAYLOAD && count == 16'(MAX_BEATS));
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            ret_addr <= '0;
            tag      <= '0;
            count    <= '0;
            sum      <= '0;
            rsp_cnt  <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (s_acc && state == IDLE) begin
                ret_addr <= AXIS_S_TDATA[TDESTW-1:0];
                tag      <= AXIS_S_TDATA[31:16];
                sum      <= '0;
                count    <= '0;
            end
            if (s_acc && state == PAYLOAD) begin
                sum   <= sum + AXIS_S_TDATA;
                count <= count == 16'(MAX_BEATS) ? count : count + 16'd1;
            end
            if (s_acc && beat_err)
                err <= 1'b1;
            if (m_acc && state == RSP_SUM && rsp_cnt != 32'(NUM_PACKETS))
                rsp_cnt <= rsp_cnt + 32'd1;
        end
    end
    always_comb begin
        state_nxt = state;
        if (state == IDLE && s_acc)
            state_nxt = AXIS_S_TLAST ? RSP_HDR : PAYLOAD;
        if (state == PAYLOAD && s_acc && AXIS_S_TLAST)
            state_nxt = RSP_HDR;
        if (state == RSP_HDR && AXIS_M_TREADY)
            state_nxt = RSP_SUM;
        if (state == RSP_SUM && AXIS_M_TREADY)
            state_nxt = IDLE;
    end
    always_comb begin
        AXIS_S_TREADY = RST_N && (state == IDLE || state == PAYLOAD);
        AXIS_M_TVALID = state == RSP_HDR || state == RSP_SUM;
        AXIS_M_TDATA  = state == RSP_HDR ? TDATAW'({tag, count}) : state == RSP_SUM ? sum : '0;
        AXIS_M_TLAST  = state == RSP_SUM;
        AXIS_M_TDEST  = AXIS_M_TVALID ? ret_addr : '0;
        DONE          = rsp_cnt == 32'(NUM_PACKETS);
        ERR           = err;
    end
endmodule

// File: tb/tb_axis_sum_responder.sv
// tb_axis_sum_responder: scoreboard bench for axis_sum_responder (NUM_PACKETS=3, MAX_BEATS=4).
// Define AXIS_SUM_RESPONDER_DEST_CHECK_EN for both bench and design to exercise the TDEST check.
module tb_axis_sum_responder;
    localparam int NP = 3;
    localparam int MAXB = 4;
    localparam logic [3:0] MY = 4'h3;
    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    logic AXIS_S_TVALID = 1'b0, AXIS_S_TLAST = 1'b0, AXIS_M_TREADY = 1'b0;
    logic [31:0] AXIS_S_TDATA = '0;
    logic [3:0] AXIS_S_TDEST = '0;
    logic AXIS_S_TREADY, AXIS_M_TVALID, AXIS_M_TLAST, DONE, ERR;
    logic [31:0] AXIS_M_TDATA;
    logic [3:0] AXIS_M_TDEST;
    typedef struct {
        logic [31:0] data;
        logic last;
        logic [3:0] dest;
        logic err;
    } rsp_t;
    rsp_t exp_q[$];
    int errs = 0, checks = 0, completed = 0;
    logic exp_err = 1'b0, hold_low = 1'b0;
    logic pv = 1'b0, pr = 1'b0, pl_last = 1'b0;
    logic [31:0] pd = '0;
    logic [3:0] pdst = '0;
    logic [31:0] pl[$];

    axis_sum_responder #(.TDATAW(32), .TDESTW(4), .NUM_PACKETS(NP), .MAX_BEATS(MAXB), .MY_ADDR(MY)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .AXIS_S_TVALID(AXIS_S_TVALID), .AXIS_S_TREADY(AXIS_S_TREADY), .AXIS_S_TDATA(AXIS_S_TDATA),
        .AXIS_S_TLAST(AXIS_S_TLAST), .AXIS_S_TDEST(AXIS_S_TDEST),
        .AXIS_M_TVALID(AXIS_M_TVALID), .AXIS_M_TREADY(AXIS_M_TREADY), .AXIS_M_TDATA(AXIS_M_TDATA),
        .AXIS_M_TLAST(AXIS_M_TLAST), .AXIS_M_TDEST(AXIS_M_TDEST),
        .DONE(DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Response ready changes just after each rising edge so it is stable at the sampling negedge
    initial forever begin
        @(posedge CLK);
        #2;
        AXIS_M_TREADY = !hold_low && ($urandom_range(3) != 0);
    end

    always @(negedge CLK) begin
        rsp_t e;
        if (!RST_N) begin
            pv = 1'b0;
        end else begin
            chk("done", DONE, completed >= NP);
            if (pv && !pr) begin
                chk("hold_valid", AXIS_M_TVALID, 1);
                chk("hold_data", AXIS_M_TDATA, pd);
                chk("hold_dest", AXIS_M_TDEST, pdst);
                chk("hold_last", AXIS_M_TLAST, pl_last);
            end
            if (AXIS_M_TVALID)
                chk("s_ready_blocked", AXIS_S_TREADY, 0);
            if (AXIS_M_TVALID && AXIS_M_TREADY) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL unexpected_beat: got %h with nothing expected", AXIS_M_TDATA);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_data", AXIS_M_TDATA, e.data);
                    chk("rsp_last", AXIS_M_TLAST, e.last);
                    chk("rsp_dest", AXIS_M_TDEST, e.dest);
                    chk("rsp_err", ERR, e.err);
                    if (e.last) completed++;
                end
            end
            pv = AXIS_M_TVALID;
            pr = AXIS_M_TREADY;
            pd = AXIS_M_TDATA;
            pdst = AXIS_M_TDEST;
            pl_last = AXIS_M_TLAST;
        end
    end

    // Reference model: response = {tag, min(n,MAX)} then sum of all payload words mod 2^32
    task automatic send(input logic [3:0] ret, input logic [15:0] tag, input logic [3:0] sdest,
                        input logic [31:0] p[$]);
        int n = p.size();
        logic [31:0] s = '0;
        logic ferr = exp_err;
        rsp_t r;
        foreach (p[i]) s += p[i];
        if (n > MAXB) ferr = 1'b1;
`ifdef AXIS_SUM_RESPONDER_DEST_CHECK_EN
        if (sdest != MY) ferr = 1'b1;
`endif
        r.data = {tag, 16'(n > MAXB ? MAXB : n)};
        r.last = 1'b0;
        r.dest = ret;
        r.err = ferr;
        exp_q.push_back(r);
        r.data = s;
        r.last = 1'b1;
        exp_q.push_back(r);
        for (int i = 0; i <= n; i++) begin
            int t = 0;
            AXIS_S_TVALID = 1'b1;
            AXIS_S_TDATA = i == 0 ? {tag, 12'h0, ret} : p[i-1];
            AXIS_S_TLAST = i == n;
            AXIS_S_TDEST = sdest;
            while (!AXIS_S_TREADY && t < 200) begin
                @(negedge CLK);
                t++;
            end
            if (t >= 200) begin
                checks++;
                errs++;
                $display("FAIL s_ready_timeout: got no TREADY within 200 cycles");
                AXIS_S_TVALID = 1'b0;
                return;
            end
            @(negedge CLK);
            if (i > MAXB) exp_err = 1'b1;
`ifdef AXIS_SUM_RESPONDER_DEST_CHECK_EN
            if (sdest != MY) exp_err = 1'b1;
`endif
            chk("err_beat", ERR, exp_err);
        end
        AXIS_S_TVALID = 1'b0;
        AXIS_S_TLAST = 1'b0;
        chk("rsp_latency", AXIS_M_TVALID, 1);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge CLK);
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errs++;
            $display("FAIL drain_timeout: got %0d responses outstanding expected 0", exp_q.size());
        end
        @(negedge CLK);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        @(negedge CLK);
        chk("rst_s_ready", AXIS_S_TREADY, 0);
        chk("rst_m_valid", AXIS_M_TVALID, 0);
        chk("rst_m_data", AXIS_M_TDATA, 0);
        chk("rst_m_last", AXIS_M_TLAST, 0);
        chk("rst_m_dest", AXIS_M_TDEST, 0);
        chk("rst_done", DONE, 0);
        chk("rst_err", ERR, 0);
        @(negedge CLK);
        #3 RST_N = 1'b1;
        @(negedge CLK);
        chk("idle_s_ready", AXIS_S_TREADY, 1);
        pl = '{32'd1, 32'd2, 32'd3};
        send(4'd2, 16'h00A5, MY, pl);
        chk("basic_hdr", AXIS_M_TDATA, 32'h00A50003);
        chk("basic_dest", AXIS_M_TDEST, 2);
        pl.delete();
        drain();
        send(4'd1, 16'h1234, MY, pl);
        chk("hdr_only", AXIS_M_TDATA, 32'h12340000);
        drain();
        chk("done_after_2", DONE, 0);
        chk("err_after_2", ERR, 0);
        hold_low = 1'b1;
        pl = '{32'hFFFFFFFF, 32'h00000002};
        send(4'd5, 16'h0007, MY, pl);
        repeat (5) begin
            chk("bp_s_ready", AXIS_S_TREADY, 0);
            chk("bp_valid", AXIS_M_TVALID, 1);
            chk("bp_data", AXIS_M_TDATA, 32'h00070002);
            @(negedge CLK);
        end
        hold_low = 1'b0;
        drain();
        chk("done_after_3", DONE, 1);
        pl = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60};
        send(4'd6, 16'hBEEF, MY, pl);
        drain();
        chk("overflow_err", ERR, 1);
        hold_low = 1'b1;
        pl = '{32'd9};
        send(4'd7, 16'h0042, MY, pl);
        @(negedge CLK);
        #3 RST_N = 1'b0;
        #1;
        chk("midrst_valid", AXIS_M_TVALID, 0);
        chk("midrst_err", ERR, 0);
        chk("midrst_done", DONE, 0);
        exp_q.delete();
        exp_err = 1'b0;
        completed = 0;
        hold_low = 1'b0;
        @(negedge CLK);
        #3 RST_N = 1'b1;
        @(negedge CLK);
        pl = '{32'd5};
        send(4'd4, 16'h0BEE, 4'd1, pl);
        drain();
        for (int k = 0; k < 40; k++) begin
            int len = $urandom_range(6);
            logic [3:0] sd = ($urandom_range(3) == 0) ? 4'($urandom) : MY;
            pl.delete();
            for (int j = 0; j < len; j++) pl.push_back($urandom);
            send(4'($urandom), 16'($urandom), sd, pl);
        end
        drain();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
